reg_file_2r1w_clr: RTL and testbench
====================================

Name: reg_file_2r1w_clr

Overview:
Parametrised successor to the team's single-port register file: 2**W entries of B bits, one synchronous write port, two independent combinational read ports. Adds optional write-to-read bypass and a hardware clear engine that zeroes the array one entry per cycle after reset or on request. Used as a scratch/config register bank in the FPGA datapath (LIDAR sample staging, RTOS-visible config).

Parameters:
B, 8, data width in bits
W, 2, address width; depth = 2**W entries
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = read returns the stored value

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  synchronous reset, active-low
clr  input  1  request a full array clear; sampled only when idle
wr_en  input  1  write strobe
w_addr  input  W  write address
w_data  input  B  write data
r_addr_a  input  W  read address, port A
r_addr_b  input  W  read address, port B
r_data_a  output  B  read data, port A (combinational)
r_data_b  output  B  read data, port B (combinational)
busy  output  1  registered; 1 while a clear is in progress
wr_drop  output  1  registered 1-cycle pulse: a write was discarded

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- FSM states: IDLE, CLEAR. Clear pointer ptr is W bits wide.
- Reset (rst_n=0 at a posedge): state<=CLEAR, ptr<=0, busy<=1, wr_drop<=0. Entry 0 is zeroed on every reset cycle.
- CLEAR: each cycle writes 0 to array[ptr] and increments ptr.
  - When ptr==2**W-1, that entry is cleared and state goes to IDLE; busy<=0 on the same edge.
  - Net effect: busy stays high exactly 2**W cycles after rst_n releases (or after clr is accepted).
- IDLE with clr=1: state<=CLEAR, ptr<=0, busy<=1 on the next edge.
  - If wr_en=1 in the same cycle, clr wins: the write is discarded and wr_drop<=1.
- IDLE with wr_en=1 and clr=0: array[w_addr]<=w_data at the posedge. Write latency is 1 cycle.
- wr_en=1 while busy: the write is discarded and wr_drop<=1 on the next edge. wr_drop is 0 in every other cycle.
- clr while busy: ignored; no restart and no extension of busy.
- rst_n=0 mid-clear: the clear restarts from ptr=0, with full 2**W cycles after release.
- Reads (combinational, both ports independent; both ports may use the same address):
  - busy=1: r_data_x = 0, regardless of partial clear progress.
  - BYPASS=1, idle, wr_en=1 and w_addr==r_addr_x: r_data_x = w_data in the same cycle.
  - Otherwise: r_data_x = array[r_addr_x].
- Reset value of outputs: busy=1, wr_drop=0, r_data_a=r_data_b=0 (forced by busy).
- No arithmetic beyond ptr increment. ptr wraps modulo 2**W but is never used past the terminal entry.

Decomposition:
- Shared package: FSM state enum (IDLE, CLEAR).
- Sub-module reg_file_clr_fsm: owns state, ptr, busy and wr_drop, and emits the internal write-enable/address/data mux selection.
- The array and read/bypass muxing stay in the top module.

Test Plan:
1. Defaults B=8, W=2. Hold rst_n=0 for 2 cycles, then release -> busy=1 for exactly 4 cycles then 0; all 4 addresses read 0x00 on both ports.
2. Idle: write 0xA5 to addr 2. Next cycle r_addr_a=2, r_addr_b=3 -> r_data_a=0xA5, r_data_b=0x00; wr_drop stays 0.
3. wr_en addr 1 data 0x3C with r_addr_a=r_addr_b=1 in the same cycle:
   - BYPASS=1 -> both read 0x3C combinationally that cycle.
   - BYPASS=0 -> both read 0x00 that cycle and 0x3C the next.
4. After test 2, assert clr together with wr_en addr 0 data 0xFF -> wr_drop high 1 cycle, busy high 4 cycles; afterwards addr 0 and addr 2 read 0x00.
5. rst_n=0 for 1 cycle when ptr=2 mid-clear -> busy remains high 4 full cycles after release; all entries read 0x00.
6. During busy: wr_en addr 3 data 0x77, plus a second clr pulse -> wr_drop pulses once; busy length is unchanged; after idle, addr 3 reads 0x00.

Source files
------------

// File: rtl/reg_file_2r1w_clr_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w_clr_pkg
// Shared types for the 2-read / 1-write register file with its clear engine.
//   clr_state_e   : clear-engine FSM states (IDLE, CLEAR)
//   NUM_RD_PORTS  : number of independent combinational read ports
// ---------------------------------------------------------------------------
package reg_file_2r1w_clr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int NUM_RD_PORTS = 2;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// ---------------------------------------------------------------------------
// reg_file_clr_fsm
// Clear engine and write arbiter for reg_file_2r1w_clr. Owns the FSM state,
// the clear pointer, busy and wr_drop. It also selects what goes into the
// storage array's single write port: user data when idle, zero when clearing.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   clr                 : clear request (only honoured when idle)
//   wr_en/w_addr/w_data : user write request
//   busy                : registered, high while a clear is in progress
//   wr_drop             : registered one-cycle pulse, a user write was discarded
//   o_mem_we/addr/data  : write port command for the storage array
// ---------------------------------------------------------------------------
module reg_file_clr_fsm
  import reg_file_2r1w_clr_pkg::*;
#(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  output logic         busy,
  output logic         wr_drop,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [B-1:0] o_mem_data
);

  localparam logic [W-1:0] LAST_ENTRY = '1;

  clr_state_e   r_state;
  clr_state_e   w_state_next;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_next;
  logic         r_busy;
  logic         w_busy_next;
  logic         r_wr_drop;
  logic         w_wr_drop_next;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_busy_next    = r_busy;
    w_wr_drop_next = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = w_addr;
    o_mem_data     = w_data;

    unique case (r_state)
      ST_IDLE: begin
        if (clr) begin
          // A clear request beats a simultaneous write.
          w_state_next   = ST_CLEAR;
          w_ptr_next     = '0;
          w_busy_next    = 1'b1;
          w_wr_drop_next = wr_en;
        end else if (wr_en) begin
          o_mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        o_mem_we       = 1'b1;
        o_mem_addr     = r_ptr;
        o_mem_data     = '0;
        w_wr_drop_next = wr_en;
        w_ptr_next     = r_ptr + W'(1);
        if (r_ptr == LAST_ENTRY) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase

    // Reset cycles keep hammering entry 0 so the restart point is already
    // zero; the remaining entries follow once reset releases.
    if (!rst_n) begin
      o_mem_we   = 1'b1;
      o_mem_addr = '0;
      o_mem_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_busy    <= w_busy_next;
      r_wr_drop <= w_wr_drop_next;
    end
  end

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: rtl/reg_file_2r1w_clr.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w_clr
// 2**W x B register file: one synchronous write port, two independent
// combinational read ports, optional same-cycle write-to-read bypass and a
// hardware clear engine that zeroes one entry per cycle after reset or clr.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   clr                  : request full clear (ignored while busy)
//   wr_en/w_addr/w_data  : write port
//   r_addr_a / r_data_a  : read port A (combinational)
//   r_addr_b / r_data_b  : read port B (combinational)
//   busy                 : high while clearing; reads return 0
//   wr_drop              : one-cycle pulse when a write was discarded
// ---------------------------------------------------------------------------
module reg_file_2r1w_clr
  import reg_file_2r1w_clr_pkg::*;
#(
  parameter int B      = 8,
  parameter int W      = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr_a,
  input  logic [W-1:0] r_addr_b,
  output logic [B-1:0] r_data_a,
  output logic [B-1:0] r_data_b,
  output logic         busy,
  output logic         wr_drop
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] r_mem [DEPTH];

  logic         w_mem_we;
  logic [W-1:0] w_mem_addr;
  logic [B-1:0] w_mem_data;

  reg_file_clr_fsm #(
    .B (B),
    .W (W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .busy       (busy),
    .wr_drop    (wr_drop),
    .o_mem_we   (w_mem_we),
    .o_mem_addr (w_mem_addr),
    .o_mem_data (w_mem_data)
  );

  // Storage has no reset of its own: the clear engine is the only way it
  // gets zeroed, and busy masks the reads until that is complete.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  logic [W-1:0] w_rd_addr [NUM_RD_PORTS];
  logic [B-1:0] w_rd_data [NUM_RD_PORTS];

  assign w_rd_addr[0] = r_addr_a;
  assign w_rd_addr[1] = r_addr_b;

  generate
    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
      logic w_hit;

      // Forwarding is keyed purely on the idle write strobe, so the read
      // ports see a write in the same cycle it is presented.
      assign w_hit = (BYPASS != 0) && !busy && wr_en && (w_addr == w_rd_addr[gi]);

      assign w_rd_data[gi] = busy  ? '0 :
                             w_hit ? w_data :
                                     r_mem[w_rd_addr[gi]];
    end
  endgenerate

  assign r_data_a = w_rd_data[0];
  assign r_data_b = w_rd_data[1];

endmodule

// File: tb/tb_reg_file_2r1w_clr.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2r1w_clr
// Self-checking bench for reg_file_2r1w_clr. Two instances share stimulus:
// one with bypass enabled, one without. A behavioural model tracks the
// visible contents, the remaining busy cycles and the drop pulse.
// ---------------------------------------------------------------------------
module tb_reg_file_2r1w_clr;

  localparam int B     = 8;
  localparam int W     = 2;
  localparam int DEPTH = 4;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         clr      = 1'b0;
  logic         wr_en    = 1'b0;
  logic [W-1:0] w_addr   = '0;
  logic [B-1:0] w_data   = '0;
  logic [W-1:0] r_addr_a = '0;
  logic [W-1:0] r_addr_b = '0;

  logic [B-1:0] ra1, rb1, ra0, rb0;
  logic         busy1, drop1, busy0, drop0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: visible contents, cycles of busy left, drop pulse.
  logic [B-1:0] m_mem [DEPTH];
  int           m_left = 0;
  logic         m_drop = 1'b0;

  always #5 clk = ~clk;

  reg_file_2r1w_clr #(.B(B), .W(W), .BYPASS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_addr_a (r_addr_a),
    .r_addr_b (r_addr_b),
    .r_data_a (ra1),
    .r_data_b (rb1),
    .busy     (busy1),
    .wr_drop  (drop1)
  );

  reg_file_2r1w_clr #(.B(B), .W(W), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_addr_a (r_addr_a),
    .r_addr_b (r_addr_b),
    .r_data_a (ra0),
    .r_data_b (rb0),
    .busy     (busy0),
    .wr_drop  (drop0)
  );

  // Expected read value given the current model state and current inputs.
  function automatic logic [B-1:0] m_read(input logic [W-1:0] a, input bit byp);
    if (m_left > 0) return '0;
    if (byp && wr_en && (w_addr == a)) return w_data;
    return m_mem[a];
  endfunction

  task automatic m_zero_all();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Apply inputs shortly after a rising edge, then let them settle.
  task automatic drive(input logic r, input logic c, input logic we,
                       input logic [W-1:0] wa, input logic [B-1:0] wd,
                       input logic [W-1:0] aa, input logic [W-1:0] ab);
    rst_n = r; clr = c; wr_en = we; w_addr = wa; w_data = wd;
    r_addr_a = aa; r_addr_b = ab;
    #2;
  endtask

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_left = DEPTH; m_drop = 1'b0; m_zero_all();
    end else if (m_left > 0) begin
      m_drop = wr_en; m_left = m_left - 1;
    end else if (clr) begin
      m_drop = wr_en; m_left = DEPTH; m_zero_all();
    end else begin
      m_drop = 1'b0;
      if (wr_en) m_mem[w_addr] = w_data;
    end
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    step();
    n_vec++;
    if (busy1 !== 1'b1 || drop1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b wr_drop=%b, required busy=1 wr_drop=0", busy1, drop1);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
      if (!busy1) break;
      cnt++;
      step();
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL reset_busy_len: busy cycles=%0d, required 4", cnt);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, W'(a), W'(a));
      n_vec++;
      if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
        n_err++;
        $display("FAIL reset_read_zero: addr %0d a=%h b=%h, required 00", a, ra1, rb1);
      end
      step();
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 1'b1, 2'd2, 8'hA5, 2'd0, 2'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3);
    n_vec++;
    if (ra1 !== 8'hA5 || rb1 !== 8'h00 || drop1 !== 1'b0) begin
      n_err++;
      $display("FAIL write_read: a=%h b=%h drop=%b, required a=a5 b=00 drop=0", ra1, rb1, drop1);
    end
    step();
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 1'b1, 2'd1, 8'h3C, 2'd1, 2'd1);
    n_vec++;
    if (ra1 !== 8'h3C || rb1 !== 8'h3C) begin
      n_err++;
      $display("FAIL bypass_on: a=%h b=%h, required 3c 3c", ra1, rb1);
    end
    n_vec++;
    if (ra0 !== 8'h00 || rb0 !== 8'h00) begin
      n_err++;
      $display("FAIL bypass_off_same: a=%h b=%h, required 00 00", ra0, rb0);
    end
    step();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd1);
    n_vec++;
    if (ra0 !== 8'h3C || rb0 !== 8'h3C || ra1 !== 8'h3C) begin
      n_err++;
      $display("FAIL bypass_off_next: nb a=%h b=%h byp a=%h, required 3c", ra0, rb0, ra1);
    end
    step();
  endtask

  task automatic test_clr_vs_write();
    int cnt;
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'hFF, 2'd2, 2'd0);
    step();
    n_vec++;
    if (drop1 !== 1'b1 || busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL clr_wins: drop=%b busy=%b, required 1 1", drop1, busy1);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd2);
      if (i == 1) begin
        n_vec++;
        if (drop1 !== 1'b0) begin
          n_err++;
          $display("FAIL clr_drop_width: drop=%b, required 0", drop1);
        end
      end
      if (!busy1) break;
      cnt++;
      step();
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL clr_busy_len: busy cycles=%0d, required 4", cnt);
    end
    n_vec++;
    if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
      n_err++;
      $display("FAIL clr_contents: addr0=%h addr2=%h, required 00 00", ra1, rb1);
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h99, 2'd0, 2'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    step();
    // Two clear cycles bring the pointer to entry 2, then pulse reset.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
      if (!busy1) break;
      cnt++;
      step();
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL rst_mid_busy_len: busy cycles=%0d, required 4", cnt);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, W'(a), W'(DEPTH - 1 - a));
      n_vec++;
      if (ra1 !== 8'h00 || rb1 !== 8'h00) begin
        n_err++;
        $display("FAIL rst_mid_zero: addr %0d a=%h b=%h, required 00", a, ra1, rb1);
      end
      step();
    end
  endtask

  task automatic test_busy_writes();
    int cnt;
    int drops;
    drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h55, 2'd0, 2'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
    n_vec++;
    if (ra1 !== 8'h55) begin
      n_err++;
      $display("FAIL busy_pre_write: a=%h, required 55", ra1);
    end
    step();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
    step();
    cnt = 0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1)      drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h77, 2'd3, 2'd3);
      else if (i == 2) drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
      else             drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
      if (drop1) drops++;
      if (!busy1) break;
      cnt++;
      step();
    end
    n_vec++;
    if (cnt !== 4 || drops !== 1) begin
      n_err++;
      $display("FAIL busy_writes: busy cycles=%0d drops=%0d, required 4 and 1", cnt, drops);
    end
    n_vec++;
    if (ra1 !== 8'h00 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL busy_write_discard: addr3=%h busy=%b, required 00 0", ra1, busy1);
    end
    step();
  endtask

  task automatic test_random();
    logic [35:0] got;
    logic [35:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), W'($urandom), B'($urandom),
            W'($urandom), W'($urandom));
      got = {busy1, drop1, ra1, rb1, busy0, drop0, ra0, rb0};
      exp = {(m_left > 0), m_drop, m_read(r_addr_a, 1'b1), m_read(r_addr_b, 1'b1),
             (m_left > 0), m_drop, m_read(r_addr_a, 1'b0), m_read(r_addr_b, 1'b0)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: got %h, required %h", i, got, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clr_vs_write();
    test_reset_mid_clear();
    test_busy_writes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
